sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, address width; depth MEM_DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_THR, default MEM_DEPTH-1, almost-full occupancy threshold (1..MEM_DEPTH).
REQ-004 SHALL have parameter AEMPTY_THR, default 1, almost-empty occupancy threshold (0..MEM_DEPTH-1).
REQ-005 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port W_INC  input  1  write request.
REQ-008 SHALL have port WR_DATA  input  DATA_WIDTH  write data bus.
REQ-009 SHALL have port R_INC  input  1  read request.
REQ-010 SHALL have port ERR_CLR  input  1  clears sticky error flags.
REQ-011 SHALL have port RD_DATA  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have ports FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  output  1 each  status flags.
REQ-013 SHALL have port COUNT  output  ADDR_WIDTH+1  current occupancy, 0..MEM_DEPTH.
REQ-014 SHALL have ports OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.

Function
REQ-015 Write SHALL be accepted iff W_INC=1 and FULL=0 at the edge; WR_DATA stored at write pointer, pointer +1.
REQ-016 Read SHALL be accepted iff R_INC=1 and EMPTY=0 at the edge; RD_DATA loads mem[read pointer] at that edge (1-cycle latency), pointer +1.
REQ-017 RD_DATA SHALL hold its value on cycles with no accepted read.
REQ-018 Pointers SHALL be ADDR_WIDTH+1-bit binary, wrapping modulo 2*MEM_DEPTH; lower ADDR_WIDTH bits address memory.
REQ-019 FULL SHALL be 1 iff pointer MSBs differ and lower bits equal; EMPTY SHALL be 1 iff pointers equal.
REQ-020 COUNT SHALL equal (write pointer - read pointer) mod 2*MEM_DEPTH; all flags decoded from registered pointers, valid the cycle after the causing edge.
REQ-021 ALMOST_FULL SHALL be COUNT >= AFULL_THR; ALMOST_EMPTY SHALL be COUNT <= AEMPTY_THR.
REQ-022 Simultaneous accepted read and write SHALL leave COUNT unchanged; read returns oldest word, never the word being written.
REQ-023 When FULL with W_INC=R_INC=1: read accepted, write rejected; COUNT becomes MEM_DEPTH-1.
REQ-024 When EMPTY with W_INC=R_INC=1: write accepted, read rejected, RD_DATA held; COUNT becomes 1.
REQ-025 Rejected requests SHALL not modify pointers, memory or RD_DATA.

Reset
REQ-026 RST=1 SHALL immediately force: pointers 0, COUNT 0, EMPTY 1, ALMOST_EMPTY 1, FULL 0, ALMOST_FULL 0, RD_DATA 0, OVERFLOW 0, UNDERFLOW 0.
REQ-027 Memory array SHALL not be reset; reset mid-operation discards all stored words.

Configuration
REQ-028 Macro SYNC_FIFO_ERR_EN defined: OVERFLOW sets on W_INC=1 with FULL=1, UNDERFLOW sets on R_INC=1 with EMPTY=1; both hold until ERR_CLR=1; set wins over clear in the same cycle.
REQ-029 Macro SYNC_FIFO_ERR_EN undefined: OVERFLOW and UNDERFLOW ports SHALL exist, tied to 0; ERR_CLR ignored; no error flops synthesised.

Structure
REQ-030 Shared package sync_fifo_pkg SHALL hold default DATA_WIDTH, ADDR_WIDTH and threshold constants.
REQ-031 Memory SHALL be sub-module sync_fifo_mem (MEM_DEPTH x DATA_WIDTH, one write port, registered read port); pointer/flag logic stays in sync_fifo.

Verification
REQ-032 Reset then write 0x11..0x18 (8 writes, defaults) -> FULL=1, COUNT=8, ALMOST_FULL=1 from COUNT=7; 9th write rejected, OVERFLOW=1 (macro on).
REQ-033 Read 8 words from full -> RD_DATA 0x11..0x18 in order, one cycle after each accepted read; EMPTY=1, COUNT=0; extra read -> UNDERFLOW=1, RD_DATA stays 0x18.
REQ-034 Full, W_INC=R_INC=1 one cycle -> COUNT=7, RD_DATA=oldest word, new write discarded; empty, both high -> COUNT=1, RD_DATA unchanged.
REQ-035 Continuous write+read for 40 cycles after prefilling 3 -> COUNT constant 3, pointers wrap repeatedly, data order preserved.
REQ-036 Assert RST mid-stream with COUNT=5 -> all outputs to reset values asynchronously; ERR_CLR pulse clears sticky flags; macro off -> flags stay 0 under the same stimulus.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO slice: word width, address width
// and the occupancy thresholds used for the almost-full/almost-empty flags.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_AEMPTY_THR = 1;

    // Almost-full defaults to one word short of full for any depth.
    function automatic int def_afull_thr(input int addr_width);
        return (1 << addr_width) - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage for sync_fifo: MEM_DEPTH x DATA_WIDTH array with one write port
// and a registered read port. Only the read register is reset; the array
// itself is left uninitialised.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write port: store the word on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: load the addressed word on an accepted read, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and
// optional sticky overflow/underflow flags (enabled by defining
// SYNC_FIFO_ERR_EN; without it both flags are tied low and ERR_CLR is ignored).
//
// Handshake: a write is accepted on a rising edge when W_INC=1 and FULL=0; a
// read is accepted when R_INC=1 and EMPTY=0. Requests made against the
// opposing flag are dropped without side effects. Read data appears on
// RD_DATA one cycle after the accepted read and holds until the next one.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_THR  = def_afull_thr(ADDR_WIDTH),
    parameter int AEMPTY_THR = DEF_AEMPTY_THR
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    input  logic                  ERR_CLR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THR[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THR[ADDR_WIDTH:0];

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                wr_en;
    logic                rd_en;

    assign wr_en = W_INC & ~FULL;
    assign rd_en = R_INC & ~EMPTY;

    assign FULL         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                          (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign EMPTY        = (wr_ptr == rd_ptr);
    assign COUNT        = wr_ptr - rd_ptr;
    assign ALMOST_FULL  = (COUNT >= AFULL_LVL);
    assign ALMOST_EMPTY = (COUNT <= AEMPTY_LVL);

    // Pointer advance on accepted requests; wraps modulo 2*MEM_DEPTH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (WR_DATA),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (RD_DATA)
    );

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags: a new error sets the flag even if ERR_CLR is high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (W_INC && FULL)  OVERFLOW  <= 1'b1;
            else if (ERR_CLR)   OVERFLOW  <= 1'b0;
            if (R_INC && EMPTY) UNDERFLOW <= 1'b1;
            else if (ERR_CLR)   UNDERFLOW <= 1'b0;
        end
    end
`else
    // Error reporting compiled out: flags tied low, clear input has no load.
    logic err_clr_unused;
    assign err_clr_unused = ERR_CLR;
    assign OVERFLOW       = 1'b0;
    assign UNDERFLOW      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with default parameters. A queue model tracks
// the FIFO contents; expected read words go to exp_q and a monitor compares
// RD_DATA on the falling edge after each accepted read.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RST;
    logic          W_INC;
    logic [DW-1:0] WR_DATA;
    logic          R_INC;
    logic          ERR_CLR;
    logic [DW-1:0] RD_DATA;
    logic          FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
    logic [AW:0]   COUNT;
    logic          OVERFLOW, UNDERFLOW;

    always #5 CLK = ~CLK;

    sync_fifo dut (
        .CLK          (CLK),
        .RST          (RST),
        .W_INC        (W_INC),
        .WR_DATA      (WR_DATA),
        .R_INC        (R_INC),
        .ERR_CLR      (ERR_CLR),
        .RD_DATA      (RD_DATA),
        .FULL         (FULL),
        .EMPTY        (EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] last_exp = '0;
    logic          ov_m = 1'b0;
    logic          un_m = 1'b0;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_status(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ":count"},  32'(COUNT), 32'(n));
        chk({tag, ":full"},   32'(FULL), 32'(n == DEPTH));
        chk({tag, ":empty"},  32'(EMPTY), 32'(n == 0));
        chk({tag, ":afull"},  32'(ALMOST_FULL), 32'(n >= DEPTH - 1));
        chk({tag, ":aempty"}, 32'(ALMOST_EMPTY), 32'(n <= 1));
        chk({tag, ":ovf"},    32'(OVERFLOW), 32'(ov_m));
        chk({tag, ":unf"},    32'(UNDERFLOW), 32'(un_m));
    endtask

    // ---------------- monitor ----------------
    // Pops one expected word per accepted read; otherwise RD_DATA must hold.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            chk("rd_data", 32'(RD_DATA), 32'(last_exp));
        end else begin
            chk("rd_hold", 32'(RD_DATA), 32'(last_exp));
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                         input logic clr, input string tag);
        bit wa, ra, full_pre, empty_pre;
        logic [DW-1:0] rv;
        full_pre  = (model_q.size() == DEPTH);
        empty_pre = (model_q.size() == 0);
        wa = w && !full_pre;
        ra = r && !empty_pre;
        W_INC = w; WR_DATA = d; R_INC = r; ERR_CLR = clr;
        @(posedge CLK);
        rv = '0;
        if (ra) rv = model_q.pop_front();
        if (wa) model_q.push_back(d);
        if (ra) exp_q.push_back(rv);
        if (ERR_EN) begin
            if (w && full_pre) ov_m = 1'b1;
            else if (clr)      ov_m = 1'b0;
            if (r && empty_pre) un_m = 1'b1;
            else if (clr)       un_m = 1'b0;
        end
        #1;
        W_INC = 1'b0; R_INC = 1'b0; ERR_CLR = 1'b0;
        check_status(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RST = 1'b1; W_INC = 1'b0; R_INC = 1'b0; ERR_CLR = 1'b0; WR_DATA = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1 RST = 1'b0;
        check_status("reset");
        chk("reset:rd_data", 32'(RD_DATA), 32'h0);

        // Fill with 0x11..0x18, flags tracked word by word.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, "fill");
        // Write while full: rejected; second attempt with ERR_CLR shows set wins.
        cycle(1'b1, 8'h99, 1'b0, 1'b0, "wr_full");
        cycle(1'b1, 8'h9a, 1'b0, 1'b1, "wr_full_clr");

        // Drain; monitor expects 0x11..0x18 in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
        cycle(1'b0, '0, 1'b1, 1'b0, "rd_empty");
        chk("rd_empty:rd_data", 32'(RD_DATA), 32'h18);
        cycle(1'b0, '0, 1'b0, 1'b1, "err_clr");

        // Full with simultaneous read/write: read wins, write dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, "fill2");
        cycle(1'b1, 8'h99, 1'b1, 1'b0, "full_rw");
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain2");
        // Empty with simultaneous read/write: write wins, RD_DATA holds 0x28.
        cycle(1'b1, 8'h55, 1'b1, 1'b0, "empty_rw");
        chk("empty_rw:rd_data", 32'(RD_DATA), 32'h28);
        cycle(1'b0, '0, 1'b1, 1'b0, "drain3");
        cycle(1'b0, '0, 1'b0, 1'b1, "err_clr2");

        // Prefill 3, then 40 cycles of streaming read+write.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "prefill");
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h43 + i), 1'b1, 1'b0, "stream");

        // Bring occupancy to 5 and reset asynchronously between edges.
        cycle(1'b1, 8'h70, 1'b0, 1'b0, "to5a");
        cycle(1'b1, 8'h71, 1'b0, 1'b0, "to5b");
        #2 RST = 1'b1;
        model_q.delete();
        exp_q.delete();
        last_exp = '0; ov_m = 1'b0; un_m = 1'b0;
        #1;
        check_status("async_rst");
        chk("async_rst:rd_data", 32'(RD_DATA), 32'h0);
        @(negedge CLK);
        #1 RST = 1'b0;

        // Stored words are gone: read rejected, then a fresh word flows through.
        cycle(1'b0, '0, 1'b1, 1'b0, "post_rst_rd");
        cycle(1'b1, 8'h77, 1'b0, 1'b0, "post_rst_wr");
        cycle(1'b0, '0, 1'b1, 1'b0, "post_rst_rd2");
        cycle(1'b0, '0, 1'b0, 1'b1, "post_rst_clr");

        repeat (2) @(posedge CLK);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
